enkel_core: RTL and testbench

- Parametrised successor to the fixed 8-bit accumulator computer top.
- Integrates in one block: program loader, multi-cycle fetch/execute FSM, accumulator ALU with carry, PC, IR and show register.
- Data and address widths are generic. The tri-state data bus is replaced by split read/write buses.
- A memory model sits outside the block on the mem_* ports.

---
 rtl/enkel_core.sv | 258 +++++++++++++++++++++++++
 tb/tb_enkel_core.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enkel_core.sv
// -----------------------------------------------------------------------------
// enkel_core
//
// Purpose:
//   Parametrised accumulator computer core. It combines a program loader, a
//   multi-cycle fetch/execute FSM, an accumulator ALU with carry, the PC, the
//   IR and a show (display) register. Memory sits outside the block on the
//   split mem_* read/write buses.
//
//   Memory read protocol: mem_rdata is valid in the cycle after a cycle with
//   mem_cs & mem_oe high. A write happens on the rising edge that ends a cycle
//   with mem_cs & mem_we high. mem_we and mem_oe are never high together, and
//   every mem_* output is 0 in any cycle that does not drive it.
//
// Optional feature (macro ENKEL_SINGLE_STEP_EN):
//   When defined, the FSM waits in FETCH, with no memory access, until step=1
//   is sampled. Each step pulse admits exactly one instruction. When the macro
//   is undefined, step has no effect.
//
// Parameters:
//   DATA_W   accumulator / memory word / show_out width (must be >= ADDR_W+3)
//   ADDR_W   PC / address field width; memory depth is 2**ADDR_W
//   PC_RESET PC value loaded on reset and on each start
//
// Ports:
//   clk             system clock, rising-edge
//   master_reset_n  synchronous active-low reset
//   start           one-cycle pulse, runs from PC_RESET (IDLE/HALT only)
//   prog_mode       selects the loader (honoured in IDLE only)
//   prog_valid      loader write request
//   prog_ready      loader accept, high in IDLE while prog_mode=1
//   prog_addr       loader address
//   prog_data       loader data
//   step            single-step advance
//   mem_cs/oe/we    memory chip select / read enable / write enable
//   mem_addr        memory address
//   mem_wdata       memory write data
//   mem_rdata       memory read data (one cycle after cs&oe)
//   show_out        display register
//   carry           carry flag
//   status          high while the FSM is outside IDLE/HALT
//   halted          high in HALT
//   dbg_state       current FSM state encoding
//   dbg_pc          current program counter
//   dbg_acc         current accumulator
//
// Instruction word: opcode = IR[DATA_W-1:DATA_W-3], address field a =
// IR[ADDR_W-1:0]. The bits in between are ignored, so only the opcode and the
// address field are kept.
// -----------------------------------------------------------------------------
module enkel_core #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned PC_RESET = 0
) (
    input  logic              clk,
    input  logic              master_reset_n,
    input  logic              start,
    input  logic              prog_mode,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              step,
    output logic              mem_cs,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] show_out,
    output logic              carry,
    output logic              status,
    output logic              halted,
    output logic [2:0]        dbg_state,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [DATA_W-1:0] dbg_acc
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOADIR = 3'd2,
        S_EXEC   = 3'd3,
        S_MEMRD  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_LD   = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_PUT  = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_JC   = 3'b101;
    localparam logic [2:0] OP_SHOW = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(PC_RESET);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_fa;
    logic [DATA_W-1:0] r_acc;
    logic              r_carry;
    logic [DATA_W-1:0] r_show;

    logic              w_step_go;
    logic              w_restart;
    logic [DATA_W:0]   w_sum;

`ifdef ENKEL_SINGLE_STEP_EN
    // FETCH only moves on, and only touches memory, in a cycle where step is high.
    assign w_step_go = step;
`else
    // Free-running: step is referenced but cannot hold the FSM.
    assign w_step_go = step | 1'b1;
`endif

    // start is honoured in IDLE (loader deselected) and in HALT (prog_mode ignored).
    assign w_restart = start &&
                       (((r_state == S_IDLE) && !prog_mode) || (r_state == S_HALT));

    // Full-width sum; the top bit becomes the carry.
    assign w_sum = {1'b0, r_acc} + {1'b0, mem_rdata};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_restart) w_next = S_FETCH;
            S_FETCH:  if (w_step_go) w_next = S_LOADIR;
            S_LOADIR: w_next = S_EXEC;
            S_EXEC: begin
                case (r_op)
                    OP_LD, OP_ADD: w_next = S_MEMRD;
                    OP_HALT:       w_next = S_HALT;
                    default:       w_next = S_FETCH;
                endcase
            end
            S_MEMRD:  w_next = S_FETCH;
            S_HALT:   if (w_restart) w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory bus and loader handshake (combinational from state)
    // ------------------------------------------------------------------
    always_comb begin
        prog_ready = 1'b0;
        mem_cs     = 1'b0;
        mem_oe     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (r_state)
            S_IDLE: begin
                prog_ready = prog_mode;
                // Loader write goes straight through to memory in the same cycle.
                if (prog_mode && prog_valid) begin
                    mem_cs    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = prog_addr;
                    mem_wdata = prog_data;
                end
            end
            S_FETCH: begin
                if (w_step_go) begin
                    mem_cs   = 1'b1;
                    mem_oe   = 1'b1;
                    mem_addr = r_pc;
                end
            end
            S_EXEC: begin
                case (r_op)
                    OP_LD, OP_ADD: begin
                        mem_cs   = 1'b1;
                        mem_oe   = 1'b1;
                        mem_addr = r_fa;
                    end
                    OP_PUT: begin
                        mem_cs    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = r_fa;
                        mem_wdata = r_acc;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!master_reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= PC_INIT;
            r_op    <= '0;
            r_fa    <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_show  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE, S_HALT: begin
                    // A (re)start clears A and carry; show_out is kept.
                    if (w_restart) begin
                        r_pc    <= PC_INIT;
                        r_acc   <= '0;
                        r_carry <= 1'b0;
                    end
                end
                S_LOADIR: begin
                    r_op <= mem_rdata[DATA_W-1 -: 3];
                    r_fa <= mem_rdata[ADDR_W-1:0];
                    // Natural wrap from the top address back to 0.
                    r_pc <= r_pc + PC_ONE;
                end
                S_EXEC: begin
                    case (r_op)
                        OP_NOT:  r_acc  <= ~r_acc;
                        OP_JMP:  r_pc   <= r_fa;
                        OP_JC:   if (r_carry) r_pc <= r_fa;
                        OP_SHOW: r_show <= r_acc;
                        default: ;
                    endcase
                end
                S_MEMRD: begin
                    // Only LD and ADD reach MEMRD.
                    if (r_op == OP_ADD) begin
                        {r_carry, r_acc} <= w_sum;
                    end else begin
                        r_acc <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign show_out  = r_show;
    assign carry     = r_carry;
    assign status    = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted    = (r_state == S_HALT);
    assign dbg_state = r_state;
    assign dbg_pc    = r_pc;
    assign dbg_acc   = r_acc;

endmodule

// File: tb/tb_enkel_core.sv
// -----------------------------------------------------------------------------
// tb_enkel_core
//
// Directed programs are loaded through the loader port into a behavioural
// memory. Before each run the expected bus events (instruction/data reads,
// data writes, entry into HALT with carry and show_out) are pushed into exp_q.
// A monitor on the falling edge pops one entry for every event the core shows
// and compares it. Reset state, latency and a few status checks are made
// directly by the driver.
//
// Valid/ready: a loader write is accepted in any cycle where prog_valid and
// prog_ready are both high; the memory takes it on that rising edge.
// -----------------------------------------------------------------------------
module tb_enkel_core;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int EW = 2 + 1 + AW + DW;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_MEMRD = 3'd4;

`ifdef ENKEL_SINGLE_STEP_EN
    localparam logic STEP_IDLE = 1'b1;
`else
    localparam logic STEP_IDLE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          prog_mode = 1'b0;
    logic          prog_valid = 1'b0;
    logic          prog_ready;
    logic [AW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_data = '0;
    logic          step = STEP_IDLE;
    logic          mem_cs, mem_oe, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] show_out;
    logic          carry, status, halted;
    logic [2:0]    dbg_state;
    logic [AW-1:0] dbg_pc;
    logic [DW-1:0] dbg_acc;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic prev_halted = 1'b0;

    enkel_core #(.DATA_W(DW), .ADDR_W(AW), .PC_RESET(0)) dut (
        .clk(clk), .master_reset_n(rst_n), .start(start),
        .prog_mode(prog_mode), .prog_valid(prog_valid), .prog_ready(prog_ready),
        .prog_addr(prog_addr), .prog_data(prog_data), .step(step),
        .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .show_out(show_out), .carry(carry), .status(status), .halted(halted),
        .dbg_state(dbg_state), .dbg_pc(dbg_pc), .dbg_acc(dbg_acc)
    );

    // ---------------- clock / memory model ----------------
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    end

    always @(posedge clk) begin
        if (mem_cs && mem_oe) mem_rdata <= mem[mem_addr];
        if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] ev_rd(input logic [AW-1:0] a);
        return {2'd0, 1'b0, a, 8'h00};
    endfunction

    function automatic logic [EW-1:0] ev_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {2'd1, 1'b0, a, d};
    endfunction

    function automatic logic [EW-1:0] ev_halt(input logic c, input logic [DW-1:0] s);
        return {2'd2, c, 5'd0, s};
    endfunction

    task automatic sb_pop(input string name, input logic [EW-1:0] obs);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: unexpected event %0h, nothing expected", name, obs);
        end else begin
            check(name, 32'(obs), 32'(exp_q.pop_front()));
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (status && mem_cs) begin
                sb_pop("mem_evt", {(mem_we ? 2'd1 : 2'd0), 1'b0, mem_addr,
                                   (mem_we ? mem_wdata : 8'h00)});
                check("we_oe_excl", 32'(mem_we & mem_oe), 32'd0);
            end
            if (halted && !prev_halted)
                sb_pop("halt_evt", {2'd2, carry, 5'd0, show_out});
        end
        prev_halted = halted;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        prog_mode  = 1'b1;
        prog_valid = 1'b1;
        prog_addr  = a;
        prog_data  = d;
        @(posedge clk); #1;
        prog_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Start and wait for HALT; optionally pokes start mid-run, which must be ignored.
    task automatic run_prog(input string name, input int exp_lat, input bit poke);
        int cnt;
        prog_mode = 1'b0;
        pulse_start();
        cnt = 0;
        while (!halted && cnt < 500) begin
            if (poke) start = (cnt == 5);
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0;
        if (!halted) check({name, "_timeout"}, 32'(halted), 32'd1);
        else if (exp_lat > 0) check({name, "_latency"}, 32'(cnt), 32'(exp_lat));
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_state",  32'(dbg_state), 32'(ST_IDLE));
        check("rst_pc",     32'(dbg_pc), 32'd0);
        check("rst_acc",    32'(dbg_acc), 32'd0);
        check("rst_carry",  32'(carry), 32'd0);
        check("rst_show",   32'(show_out), 32'd0);
        check("rst_status", 32'({status, halted, prog_ready}), 32'd0);
        check("rst_mem",    32'({mem_cs, mem_oe, mem_we, mem_addr, mem_wdata}), 32'd0);

        // Program 1: LD 16, ADD 17, SHOW, HALT with 0x7F + 0x81
        load(5'd0, 8'h10); load(5'd1, 8'h31); load(5'd2, 8'hC0); load(5'd3, 8'hE0);
        load(5'd16, 8'h7F); load(5'd17, 8'h81);
        check("prog_ready_on", 32'(prog_ready), 32'd1);
        pulse_start();  // prog_mode=1: must be ignored
        check("start_in_prog", 32'(dbg_state), 32'(ST_IDLE));
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(ev_rd(5'd0));  exp_q.push_back(ev_rd(5'd16));
            exp_q.push_back(ev_rd(5'd1));  exp_q.push_back(ev_rd(5'd17));
            exp_q.push_back(ev_rd(5'd2));  exp_q.push_back(ev_rd(5'd3));
            exp_q.push_back(ev_halt(1'b1, 8'h00));
            run_prog("p1", 14, 1'b0);   // second pass restarts from HALT
        end
        // In HALT the loader stays closed
        prog_mode = 1'b1; prog_valid = 1'b1;
        #1;
        check("halt_no_loader", 32'({prog_ready, mem_cs, mem_we}), 32'd0);
        prog_valid = 1'b0; prog_mode = 1'b0;

        // Program 2: PUT then LD of the same word, NOT in between
        do_reset();
        load(5'd0, 8'h10); load(5'd1, 8'h74); load(5'd2, 8'h40); load(5'd3, 8'h14);
        load(5'd4, 8'hC0); load(5'd5, 8'hE0); load(5'd16, 8'hA5); load(5'd20, 8'h00);
        exp_q.push_back(ev_rd(5'd0));  exp_q.push_back(ev_rd(5'd16));
        exp_q.push_back(ev_rd(5'd1));  exp_q.push_back(ev_wr(5'd20, 8'hA5));
        exp_q.push_back(ev_rd(5'd2));  exp_q.push_back(ev_rd(5'd3));
        exp_q.push_back(ev_rd(5'd20)); exp_q.push_back(ev_rd(5'd4));
        exp_q.push_back(ev_rd(5'd5));  exp_q.push_back(ev_halt(1'b0, 8'hA5));
        run_prog("p2", 0, 1'b0);
        check("p2_acc", 32'(dbg_acc), 32'hA5);

        // Program 3: JC not taken, overflowing ADD, JC taken; start poked mid-run
        do_reset();
        load(5'd0, 8'hA5); load(5'd1, 8'h10); load(5'd2, 8'h31); load(5'd3, 8'hA5);
        load(5'd4, 8'hE0); load(5'd5, 8'hC0); load(5'd6, 8'hE0);
        load(5'd16, 8'hFF); load(5'd17, 8'h02);
        exp_q.push_back(ev_rd(5'd0));  exp_q.push_back(ev_rd(5'd1));
        exp_q.push_back(ev_rd(5'd16)); exp_q.push_back(ev_rd(5'd2));
        exp_q.push_back(ev_rd(5'd17)); exp_q.push_back(ev_rd(5'd3));
        exp_q.push_back(ev_rd(5'd5));  exp_q.push_back(ev_rd(5'd6));
        exp_q.push_back(ev_halt(1'b1, 8'h01));
        run_prog("p3", 0, 1'b1);

        // Program 4: PC wraps from 31 to 0
        do_reset();
        load(5'd0, 8'hA3); load(5'd1, 8'h9E); load(5'd2, 8'hE0); load(5'd3, 8'hC0);
        load(5'd4, 8'hE0); load(5'd30, 8'h40); load(5'd31, 8'h30); load(5'd16, 8'h01);
        exp_q.push_back(ev_rd(5'd0));  exp_q.push_back(ev_rd(5'd1));
        exp_q.push_back(ev_rd(5'd30)); exp_q.push_back(ev_rd(5'd31));
        exp_q.push_back(ev_rd(5'd16)); exp_q.push_back(ev_rd(5'd0));
        exp_q.push_back(ev_rd(5'd3));  exp_q.push_back(ev_rd(5'd4));
        exp_q.push_back(ev_halt(1'b1, 8'h00));
        run_prog("p4", 0, 1'b0);

        // Program 5: reset during the MEMRD of an ADD
        do_reset();
        load(5'd0, 8'h11); load(5'd1, 8'h30); load(5'd16, 8'hFF); load(5'd17, 8'hFF);
        exp_q.push_back(ev_rd(5'd0));  exp_q.push_back(ev_rd(5'd17));
        exp_q.push_back(ev_rd(5'd1));  exp_q.push_back(ev_rd(5'd16));
        prog_mode = 1'b0;
        pulse_start();
        cnt = 0;
        while (!(dbg_state == ST_MEMRD && dbg_pc == 5'd2) && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("p5_reach_memrd", 32'(cnt < 100), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("p5_state", 32'(dbg_state), 32'(ST_IDLE));
        check("p5_acc_carry", 32'({dbg_acc, carry}), 32'd0);
        check("p5_pc", 32'(dbg_pc), 32'd0);
        check("p5_mem", 32'({mem_cs, mem_oe, mem_we, mem_addr, mem_wdata}), 32'd0);
        check("p5_status", 32'(status), 32'd0);

`ifdef ENKEL_SINGLE_STEP_EN
        // Single step: FETCH waits for step, one instruction per pulse
        do_reset();
        step = 1'b0;
        load(5'd0, 8'h40); load(5'd1, 8'hE0);
        exp_q.push_back(ev_rd(5'd0)); exp_q.push_back(ev_rd(5'd1));
        exp_q.push_back(ev_halt(1'b0, 8'h00));
        prog_mode = 1'b0;
        pulse_start();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_cs) cnt++;
            @(posedge clk); #1;
        end
        check("ss_no_cs", 32'(cnt), 32'd0);
        check("ss_wait", 32'({status, dbg_state}), 32'({1'b1, ST_FETCH}));
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("ss_one_instr", 32'({dbg_state, dbg_acc, mem_cs}), 32'({ST_FETCH, 8'hFF, 1'b0}));
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        cnt = 0;
        while (!halted && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("ss_halted", 32'(halted), 32'd1);
        step = STEP_IDLE;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
